seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
// State encoding and the default operand width.
package div_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Pure combinational; the caller iterates it once per cycle.
module div_step
  import div_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic [width-1:0] prem,
  input  logic [width:0]   dvs,
  input  logic             nbit,
  output logic [width-1:0] nrem,
  output logic             qbit
);

  logic [width:0] t;

  // prem < dvs always holds, so the result fits back in width bits
  always_comb begin
    t    = {prem, nbit};
    qbit = (t >= dvs);
    nrem = qbit ? width'(t - dvs) : t[width-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: IDLE -> RUN -> FIX -> DONE.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Begin,
  input  logic [width-1:0] Dividend,
  input  logic [width-1:0] Divisor,
  output logic [width-1:0] Quotient,
  output logic [width-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int cw = $clog2(width + 1);

  state_t           state;
  logic [cw-1:0]    cnt;
  logic [width-1:0] prem;
  logic [width-1:0] qr;
  logic [width-1:0] qout;
  logic [width-1:0] rout;
  logic [width:0]   dvs;
  logic [width:0]   ea;
  logic [width:0]   eb;
  logic [width:0]   ma;
  logic [width:0]   mb;
  logic [width-1:0] nrem;
  logic [width-1:0] qfix;
  logic [width-1:0] rfix;
  logic             qbit;
  logic             sa;
  logic             sb;
  logic             zf;
  logic             busy;
  logic             done;
  logic             dbz;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             nq;
  logic             nr;
`endif

  // Magnitudes in width+1 bits so -2^(width-1) does not overflow
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    sa = Dividend[width-1];
    sb = Divisor[width-1];
`else
    sa = 1'b0;
    sb = 1'b0;
`endif
    ea = {sa, Dividend};
    eb = {sb, Divisor};
    ma = sa ? -ea : ea;
    mb = sb ? -eb : eb;
  end

  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    qfix = nq ? -qr : qr;
    rfix = nr ? -prem : prem;
`else
    qfix = qr;
    rfix = prem;
`endif
  end

  div_step #(
    .width(width)
  ) u_step (
    .prem(prem),
    .dvs (dvs),
    .nbit(qr[width-1]),
    .nrem(nrem),
    .qbit(qbit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      prem  <= '0;
      qr    <= '0;
      dvs   <= '0;
      qout  <= '0;
      rout  <= '0;
      zf    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      nq    <= 1'b0;
      nr    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Begin) begin
            done <= 1'b0;
            dbz  <= 1'b0;
            busy <= 1'b1;
            prem <= '0;
            dvs  <= mb;
            cnt  <= cw'(width);
            zf   <= (Divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            nq   <= sa ^ sb;
            nr   <= sa;
`endif
            // Zero divisor keeps the raw dividend for Remainder
            if (Divisor == '0) begin
              qr    <= Dividend;
              state <= FIX;
            end else begin
              qr    <= width'(ma);
              state <= RUN;
            end
          end
        end
        RUN: begin
          prem <= nrem;
          qr   <= {qr[width-2:0], qbit};
          cnt  <= cnt - cw'(1);
          if (cnt == cw'(1))
            state <= FIX;
        end
        FIX: begin
          qout  <= zf ? '1 : qfix;
          rout  <= zf ? qr : rfix;
          dbz   <= zf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
      endcase
    end
  end

  assign Quotient  = qout;
  assign Remainder = rout;
  assign Busy      = busy;
  assign Done      = done;
  assign DivByZero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic model.
// Follows SEQ_DIVIDER_SIGNED_EN to pick signed or unsigned expectations.
module tb_seq_divider;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Begin = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n = 0;

  seq_divider #(
    .width(W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Begin    (Begin),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         z
  );
    int ia;
    int ib;
    z = (b == '0);
    ia = 0;
    ib = 0;
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      ia = int'($signed(a));
      ib = int'($signed(b));
      q = W'(ia / ib);
      r = W'(ia % ib);
`else
      ia = int'(a);
      ib = int'(b);
      q = W'(ia / ib);
      r = W'(ia % ib);
`endif
    end
  endfunction

  // Caller is at a negedge; edge N is the next posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    Begin = 1'b1;
    Dividend = a;
    Divisor = b;
    @(posedge CLK);
    @(negedge CLK);
    n = cyc;
    Begin = 1'b0;
  endtask

  // lat counts edges from N to the edge that first samples Done=1
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) begin
        lat = cyc - n + 1;
        break;
      end
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks += 5;
    if (Quotient !== '0) begin
      n_fail++; $display("FAIL rst_q got %h want 0", Quotient);
    end
    if (Remainder !== '0) begin
      n_fail++; $display("FAIL rst_r got %h want 0", Remainder);
    end
    if (Busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got %b want 0", Busy);
    end
    if (Done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done got %b want 0", Done);
    end
    if (DivByZero !== 1'b0) begin
      n_fail++; $display("FAIL rst_dbz got %b want 0", DivByZero);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[5];
    logic [W-1:0] vb[5];
    logic [W-1:0] vq[5];
    logic [W-1:0] vr[5];
    logic         vz[5];
    int lat;
    int elat;
    bit bok;
`ifdef SEQ_DIVIDER_SIGNED_EN
    va = '{16'h8000, 16'h07FF, 16'hFFFF, 16'h1234, 16'h8000};
    vb = '{16'h0045, 16'h00FF, 16'h00FF, 16'h0000, 16'hFFFF};
    vq = '{16'hFE26, 16'h0008, 16'h0000, 16'hFFFF, 16'h8000};
    vr = '{16'hFFC2, 16'h0007, 16'hFFFF, 16'h1234, 16'h0000};
`else
    va = '{16'hFFFF, 16'h07FF, 16'h8000, 16'h1234, 16'h8000};
    vb = '{16'h00FF, 16'h00FF, 16'h0045, 16'h0000, 16'hFFFF};
    vq = '{16'h0101, 16'h0008, 16'h01DA, 16'hFFFF, 16'h0000};
    vr = '{16'h0000, 16'h0007, 16'h003E, 16'h1234, 16'h8000};
`endif
    vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      elat = vz[i] ? 2 : W + 2;
      start_op(va[i], vb[i]);
      wait_done(lat, bok);
      n_checks += 5;
      if (Quotient !== vq[i]) begin
        n_fail++; $display("FAIL vec%0d_q got %h want %h", i, Quotient, vq[i]);
      end
      if (Remainder !== vr[i]) begin
        n_fail++; $display("FAIL vec%0d_r got %h want %h", i, Remainder, vr[i]);
      end
      if (DivByZero !== vz[i]) begin
        n_fail++; $display("FAIL vec%0d_dbz got %b want %b", i, DivByZero, vz[i]);
      end
      if (lat != elat) begin
        n_fail++; $display("FAIL vec%0d_lat got %0d want %0d", i, lat, elat);
      end
      if (!bok || Busy !== 1'b0) begin
        n_fail++; $display("FAIL vec%0d_busy got ok=%b end=%b want 1/0", i, bok, Busy);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int lat;
    int elat;
    int sel;
    bit bok;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = '0;
      else if (sel < 3) b = W'($urandom_range(1, 15));
      else if (sel == 3) b = '1;
      else b = W'($urandom);
      if ($urandom_range(0, 9) == 0) a = 16'h8000;
      if (sel < 3 && $urandom_range(0, 1) == 1) b = -b;
      model(a, b, eq, er, ez);
      elat = ez ? 2 : W + 2;
      start_op(a, b);
      wait_done(lat, bok);
      n_checks += 4;
      if (Quotient !== eq) begin
        n_fail++; $display("FAIL rnd_q %h/%h got %h want %h", a, b, Quotient, eq);
      end
      if (Remainder !== er) begin
        n_fail++; $display("FAIL rnd_r %h/%h got %h want %h", a, b, Remainder, er);
      end
      if (DivByZero !== ez) begin
        n_fail++; $display("FAIL rnd_dbz %h/%h got %b want %b", a, b, DivByZero, ez);
      end
      if (lat != elat || !bok) begin
        n_fail++; $display("FAIL rnd_lat %h/%h got %0d/%b want %0d/1", a, b, lat, bok, elat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int lat;
    bit bok;
    model(16'h8000, 16'h0045, eq, er, ez);
    start_op(16'h8000, 16'h0045);
    repeat (4) @(negedge CLK);
    Begin = 1'b1;
    Dividend = 16'h0100;
    Divisor = 16'h0003;
    @(negedge CLK);
    Begin = 1'b0;
    wait_done(lat, bok);
    n_checks += 3;
    if (Quotient !== eq || Remainder !== er) begin
      n_fail++; $display("FAIL b2b_ignore got %h/%h want %h/%h", Quotient, Remainder, eq, er);
    end
    if (lat != W + 2) begin
      n_fail++; $display("FAIL b2b_lat got %0d want %0d", lat, W + 2);
    end
    if (!bok) begin
      n_fail++; $display("FAIL b2b_busy got 0 want 1");
    end
    repeat (3) @(negedge CLK);
    n_checks += 1;
    if (Done !== 1'b1 || Quotient !== eq) begin
      n_fail++; $display("FAIL b2b_hold got %b/%h want 1/%h", Done, Quotient, eq);
    end
    model(16'h0064, 16'h0007, eq, er, ez);
    start_op(16'h0064, 16'h0007);
    n_checks += 1;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got %b/%b want 0/1", Done, Busy);
    end
    wait_done(lat, bok);
    n_checks += 1;
    if (Quotient !== eq || Remainder !== er || lat != W + 2) begin
      n_fail++; $display("FAIL b2b_second got %h/%h/%0d want %h/%h/%0d", Quotient, Remainder, lat, eq, er, W + 2);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int lat;
    bit bok;
    start_op(16'h7FFF, 16'h0013);
    repeat (7) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    n_checks += 1;
    if (Quotient !== '0 || Remainder !== '0 || Busy !== 1'b0 ||
        Done !== 1'b0 || DivByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out got q=%h r=%h b=%b d=%b z=%b want all 0",
               Quotient, Remainder, Busy, Done, DivByZero);
    end
    @(negedge CLK);
    RST = 1'b0;
    model(16'hFF00, 16'h0011, eq, er, ez);
    start_op(16'hFF00, 16'h0011);
    wait_done(lat, bok);
    n_checks += 2;
    if (Quotient !== eq || Remainder !== er || DivByZero !== ez) begin
      n_fail++; $display("FAIL midrst_new got %h/%h want %h/%h", Quotient, Remainder, eq, er);
    end
    if (lat != W + 2 || !bok) begin
      n_fail++; $display("FAIL midrst_lat got %0d/%b want %0d/1", lat, bok, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
